// File: rtl/fifo18e2_ctrl.sv
// -----------------------------------------------------------------------------
// fifo18e2_ctrl
//
// Reset/flush sequencer and flow-control guard for one FIFO18E2 wrapper used
// in common-clock, first-word-fall-through mode. It drives the primitive reset,
// waits for the primitive's reset-busy flags to clear, and only then lets
// producer and consumer handshakes turn into WREN/RDEN pulses. It also keeps a
// count of accepted words. DIN/DOUT bypass this block entirely.
//
// Ports
//   clk            sole clock (also the wrapper RDCLK/WRCLK)
//   rst            asynchronous active-high reset
//   clr            flush request, sampled every cycle
//   enq_valid      producer offers the word currently on wrapper DIN
//   enq_ready      enqueue is accepted this cycle if enq_valid
//   deq_valid      wrapper DOUT holds a valid head word
//   deq_ready      consumer takes the head word
//   fifo_rst_n     wrapper RST_N (wrapper CLR is tied low outside this block)
//   fifo_wren      wrapper WREN
//   fifo_rden      wrapper RDEN
//   fifo_empty_n   wrapper EMPTY_N
//   fifo_full_n    wrapper FULL_N
//   fifo_rdrstbusy wrapper RDRSTBUSY
//   fifo_wrrstbusy wrapper WRRSTBUSY
//   busy           high whenever the sequencer is not in RUN
//   count          accepted-but-not-dequeued words
//   err            sticky settle-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module fifo18e2_ctrl #(
   parameter int DEPTH          = 512,
   parameter int RST_CYCLES     = 5,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CW             = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          enq_valid,
   output logic          enq_ready,
   output logic          deq_valid,
   input  logic          deq_ready,
   output logic          fifo_rst_n,
   output logic          fifo_wren,
   output logic          fifo_rden,
   input  logic          fifo_empty_n,
   input  logic          fifo_full_n,
   input  logic          fifo_rdrstbusy,
   input  logic          fifo_wrrstbusy,
   output logic          busy,
   output logic [CW-1:0] count,
   output logic          err
);

   // One phase counter serves both the reset hold and the settle window, so
   // it must be wide enough for the larger of the two limits.
   localparam int PH_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int PW     = $clog2(PH_MAX + 1);

   localparam logic [PW-1:0] RST_LAST     = PW'(RST_CYCLES - 1);
   localparam logic [PW-1:0] SETTLE_LAST  = PW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] TIMEOUT_LAST = PW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      RSTA   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   phase_reg, phase_next;
   logic [CW-1:0]   count_reg, count_next;
   logic            err_reg, err_next;
   logic            in_run;
   logic            any_busy;

   assign any_busy = fifo_rdrstbusy | fifo_wrrstbusy;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RSTA;
         phase_reg <= '0;
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      err_next   = err_reg;

      if (clr) begin
         // A flush from any state restarts the reset hold from zero.
         state_next = RSTA;
         phase_next = '0;
      end else begin
         case (state_reg)
            RSTA: begin
               if (phase_reg == RST_LAST) begin
                  state_next = SETTLE;
                  phase_next = '0;
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
            SETTLE: begin
               // A clean exit takes priority over a timeout in the same cycle.
               if ((phase_reg >= SETTLE_LAST) && !any_busy) begin
                  state_next = RUN;
                  phase_next = '0;
               end else if (phase_reg == TIMEOUT_LAST) begin
                  state_next = RSTA;
                  phase_next = '0;
                  err_next   = 1'b1;
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
            RUN: begin
               phase_next = phase_reg;
            end
            default: begin
               state_next = RSTA;
               phase_next = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Handshake gating: zero-latency, combinational from inputs and state.
   // Each side is blocked only by its own busy flag so a stray reset-busy
   // pulse in RUN stalls just the affected direction.
   // -------------------------------------------------------------------------
   assign in_run     = (state_reg == RUN);
   assign enq_ready  = in_run & fifo_full_n  & ~fifo_wrrstbusy & ~clr;
   assign deq_valid  = in_run & fifo_empty_n & ~fifo_rdrstbusy & ~clr;
   assign fifo_wren  = enq_valid & enq_ready;
   assign fifo_rden  = deq_valid & deq_ready;
   assign fifo_rst_n = (state_reg != RSTA);
   assign busy       = ~in_run;

   // -------------------------------------------------------------------------
   // Occupancy. The FULL/EMPTY gating keeps it within 0..DEPTH, so no
   // saturation is needed. Any entry into (or stay in) RSTA empties it.
   // -------------------------------------------------------------------------
   always_comb begin
      count_next = count_reg;
      if (state_next == RSTA) begin
         count_next = '0;
      end else begin
         case ({fifo_wren, fifo_rden})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   assign count = count_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_fifo18e2_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fifo18e2_ctrl: a behavioural FIFO primitive, a timing/
// occupancy reference model derived from the sequencing rules, random traffic
// and directed reset/flush/timeout scenarios.
// -----------------------------------------------------------------------------
module tb_fifo18e2_ctrl;

   localparam int DEPTH = 512;
   localparam int RSTC  = 5;
   localparam int SETC  = 8;
   localparam int TOC   = 64;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int BUSY_REL = 3;   // primitive busy stays high this many edges after release

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clr = 1'b0;
   logic          enq_valid = 1'b0;
   logic          deq_ready = 1'b0;
   logic [15:0]   din = '0;
   logic          stuck = 1'b0;

   logic          enq_ready, deq_valid, fifo_rst_n, fifo_wren, fifo_rden;
   logic          busy, err;
   logic [CW-1:0] count;

   // Primitive model
   logic [15:0] prim_mem [0:DEPTH-1];
   int          pcnt = 0;
   int          wp = 0;
   int          rp = 0;
   int          bcnt = BUSY_REL;
   logic        prim_full_n, prim_empty_n, prim_busy;
   logic [15:0] prim_dout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fifo18e2_ctrl #(
      .DEPTH(DEPTH), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC), .TIMEOUT_CYCLES(TOC)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .fifo_rst_n(fifo_rst_n), .fifo_wren(fifo_wren), .fifo_rden(fifo_rden),
      .fifo_empty_n(prim_empty_n), .fifo_full_n(prim_full_n),
      .fifo_rdrstbusy(prim_busy), .fifo_wrrstbusy(prim_busy),
      .busy(busy), .count(count), .err(err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural FIFO18E2 (FWFT, common clock) -------------
   assign prim_full_n  = (pcnt < DEPTH);
   assign prim_empty_n = (pcnt != 0);
   assign prim_busy    = stuck || (bcnt != 0);
   assign prim_dout    = prim_mem[rp];

   always @(posedge clk) begin
      if (!fifo_rst_n) begin
         pcnt <= 0;
         wp   <= 0;
         rp   <= 0;
         bcnt <= BUSY_REL;
      end else begin
         int w, r;
         w = (fifo_wren && pcnt < DEPTH) ? 1 : 0;
         r = (fifo_rden && pcnt > 0) ? 1 : 0;
         if (bcnt > 0) bcnt <= bcnt - 1;
         if (w == 1) begin
            prim_mem[wp] <= din;
            wp <= (wp + 1) % DEPTH;
         end
         if (r == 1) rp <= (rp + 1) % DEPTH;
         pcnt <= pcnt + w - r;
      end
   end

   // ---------------- reference model --------------------------------------
   // m_e counts edges since the last reset release / flush / retry anchor.
   int          m_e = 0;
   logic        m_run = 1'b0;
   int          m_count = 0;
   logic        m_err = 1'b0;
   logic [15:0] sb [$];
   logic        x_enq_ready, x_deq_valid, x_wren, x_rden;

   always_comb begin
      x_enq_ready = m_run && prim_full_n  && !prim_busy && !clr;
      x_deq_valid = m_run && prim_empty_n && !prim_busy && !clr;
      x_wren      = enq_valid && x_enq_ready;
      x_rden      = x_deq_valid && deq_ready;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_e <= 0; m_run <= 1'b0; m_count <= 0; m_err <= 1'b0;
         sb.delete();
      end else if (clr) begin
         m_e <= 0; m_run <= 1'b0; m_count <= 0;
         sb.delete();
      end else if (!m_run && m_e >= RSTC + SETC - 1 && !prim_busy) begin
         m_run <= 1'b1;
         m_e   <= m_e + 1;
      end else if (!m_run && m_e == RSTC + TOC - 1) begin
         m_err <= 1'b1; m_e <= 0; m_count <= 0;
         sb.delete();
      end else begin
         if (m_e < 1000000) m_e <= m_e + 1;
         m_count <= m_count + (x_wren ? 1 : 0) - (x_rden ? 1 : 0);
         if (x_rden) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               chk("dout", int'(prim_dout), int'(sb[0]));
               void'(sb.pop_front());
            end
         end
         if (x_wren) sb.push_back(din);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("enq_ready",  int'(enq_ready),  int'(x_enq_ready));
      chk("deq_valid",  int'(deq_valid),  int'(x_deq_valid));
      chk("fifo_wren",  int'(fifo_wren),  int'(x_wren));
      chk("fifo_rden",  int'(fifo_rden),  int'(x_rden));
      chk("busy",       int'(busy),       int'(!m_run));
      chk("fifo_rst_n", int'(fifo_rst_n), int'(!rst && m_e >= RSTC));
      chk("count",      int'(count),      m_count);
      chk("err",        int'(err),        int'(m_err));
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
      din = 16'($urandom);
   endtask

   task automatic wait_run(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      if (busy) chk({tag, "_timeout"}, 1, 0);
   endtask

   task automatic fill_to(input int target);
      int n = 0;
      enq_valid = 1'b1;
      deq_ready = 1'b0;
      while (int'(count) < target && n < 2 * DEPTH) begin
         if (int'(count) == target - 1) begin
            step();
            enq_valid = 1'b0;
         end else step();
         n++;
      end
      enq_valid = 1'b0;
      if (int'(count) != target) chk("fill_to_timeout", int'(count), target);
   endtask

   task automatic drain();
      int n = 0;
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      while (deq_valid && n < 2 * DEPTH) begin
         step();
         n++;
      end
      deq_ready = 1'b0;
      if (deq_valid) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rsth, k;

      // ---- power-up ----
      #1 rst = 1'b1;
      #2;
      chk("rst_busy",   int'(busy), 1);
      chk("rst_rstn",   int'(fifo_rst_n), 0);
      chk("rst_count",  int'(count), 0);
      chk("rst_err",    int'(err), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      n = 0; rsth = -1;
      while (busy && n < 200) begin
         step();
         n++;
         if (fifo_rst_n && rsth < 0) rsth = n;
      end
      chk("pwr_rstn_edge", rsth, RSTC);
      chk("pwr_run_edge",  n, RSTC + SETC);
      chk("pwr_count",     int'(count), 0);

      // ---- fill to full, then drain ----
      enq_valid = 1'b1;
      repeat (DEPTH + 10) step();
      chk("full_count", int'(count), DEPTH);
      chk("full_ready", int'(enq_ready), 0);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      repeat (DEPTH + 10) step();
      chk("empty_count", int'(count), 0);
      chk("empty_valid", int'(deq_valid), 0);
      deq_ready = 1'b0;

      // ---- simultaneous enq/deq at count 10 ----
      fill_to(10);
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      repeat (100) step();
      chk("simul_count", int'(count), 10);
      enq_valid = 1'b0;
      deq_ready = 1'b0;

      // ---- random traffic ----
      for (int i = 0; i < 400; i++) begin
         enq_valid = ($urandom_range(0, 99) < 60);
         deq_ready = ($urandom_range(0, 99) < 45);
         step();
      end
      drain();

      // ---- CLR at count 37 alongside an enqueue ----
      fill_to(37);
      chk("pre_clr_count", int'(count), 37);
      clr = 1'b1;
      enq_valid = 1'b1;
      #1;
      chk("clr_no_wren", int'(fifo_wren), 0);
      step();
      clr = 1'b0;
      enq_valid = 1'b0;
      chk("clr_count", int'(count), 0);
      k = 0;
      while (busy && k < 200) begin
         k++;
         step();
      end
      chk("clr_busy_cycles", k, RSTC + SETC);
      chk("clr_deq_valid", int'(deq_valid), 0);

      // ---- stuck busy -> settle timeout and retry ----
      stuck = 1'b1;
      clr = 1'b1;
      step();
      clr = 1'b0;
      n = 0;
      while (!err && n < 300) begin
         step();
         n++;
      end
      chk("timeout_edge", n, RSTC + TOC);
      chk("timeout_rstn", int'(fifo_rst_n), 0);
      repeat (20) step();
      stuck = 1'b0;
      wait_run("retry_run", 200);
      chk("retry_busy", int'(busy), 0);
      chk("retry_err",  int'(err), 1);

      // ---- asynchronous reset mid-stream at count 20 ----
      fill_to(20);
      chk("pre_rst_count", int'(count), 20);
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",  int'(busy), 1);
      chk("arst_count", int'(count), 0);
      chk("arst_err",   int'(err), 0);
      chk("arst_rstn",  int'(fifo_rst_n), 0);
      chk("arst_wren",  int'(fifo_wren), 0);
      chk("arst_rden",  int'(fifo_rden), 0);
      chk("arst_enq_ready", int'(enq_ready), 0);
      chk("arst_deq_valid", int'(deq_valid), 0);
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      wait_run("post_rst_run", 200);
      chk("post_rst_count", int'(count), 0);
      chk("post_rst_err",   int'(err), 0);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
